// File: rtl/rx_descaper.sv
// Per-lane receive un-escaper: strips ESC+ESC / ESC+IDLE / ESC+SYNC pairs,
// forwards payload units, decodes sync words and counts protocol errors.
module rx_descaper #(
    parameter int unsigned UNITWIDTH  = 16,
    parameter int unsigned LANENUMBER = 4,
    parameter logic [UNITWIDTH-1:0] ESC_CHAR  = 16'h7E5A,
    parameter logic [UNITWIDTH-1:0] IDLE_CHAR = 16'h7E00,
    parameter logic [UNITWIDTH-8-LANENUMBER:0] SYNC_CHAR = 5'h1D
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_enable,
    input  logic [2:0]            in_lane_id,
    input  logic                  in_rxdata_en,
    input  logic [UNITWIDTH-1:0]  in_rxdata,
    output logic                  out_rxdata_en,
    output logic [UNITWIDTH-1:0]  out_rxdata,
    output logic                  out_idle,
    output logic                  out_sync,
    output logic [LANENUMBER-1:0] out_remote_blocklock,
    output logic                  out_aligned,
    output logic                  out_err,
    output logic [15:0]           out_err_cnt
);

    localparam int unsigned SYNCW = UNITWIDTH - 7 - LANENUMBER;

    typedef enum logic {
        NORMAL,
        GOT_ESC
    } state_t;

    state_t                  state_q, state_d;
    logic                    rxdata_en_d, idle_d, sync_d, err_d, aligned_d;
    logic [UNITWIDTH-1:0]    rxdata_d;
    logic [LANENUMBER-1:0]   blocklock_d;
    logic [15:0]             err_cnt_d;
    logic                    consume;
    logic                    sync_ok;

    assign consume = in_enable && in_rxdata_en;

    // Sync word: tag in MSBs, then lane id, reserved zero nibble, blocklock field.
    assign sync_ok = (in_rxdata[UNITWIDTH-1 -: SYNCW] == SYNC_CHAR) &&
                     (in_rxdata[LANENUMBER+6:LANENUMBER+4] == in_lane_id) &&
                     (in_rxdata[LANENUMBER+3:LANENUMBER] == '0);

    always_comb begin
        state_d     = state_q;
        rxdata_en_d = 1'b0;
        rxdata_d    = out_rxdata;
        idle_d      = 1'b0;
        sync_d      = 1'b0;
        err_d       = 1'b0;
        blocklock_d = out_remote_blocklock;
        aligned_d   = out_aligned;
        err_cnt_d   = out_err_cnt;
        if (consume) begin
            case (state_q)
                NORMAL: begin
                    if (in_rxdata == ESC_CHAR) begin
                        state_d = GOT_ESC;
                    end else begin
                        rxdata_en_d = 1'b1;
                        rxdata_d    = in_rxdata;
                    end
                end
                GOT_ESC: begin
                    state_d = NORMAL;
                    if (in_rxdata == ESC_CHAR) begin
                        rxdata_en_d = 1'b1;
                        rxdata_d    = ESC_CHAR;
                    end else if (in_rxdata == IDLE_CHAR) begin
                        idle_d = 1'b1;
                    end else if (sync_ok) begin
                        sync_d      = 1'b1;
                        blocklock_d = in_rxdata[LANENUMBER-1:0];
                        aligned_d   = 1'b1;
                    end else begin
                        err_d     = 1'b1;
                        aligned_d = 1'b0;
                        if (out_err_cnt != '1) begin
                            err_cnt_d = out_err_cnt + 16'd1;
                        end
                    end
                end
                default: state_d = NORMAL;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q              <= NORMAL;
            out_rxdata_en        <= 1'b0;
            out_rxdata           <= '0;
            out_idle             <= 1'b0;
            out_sync             <= 1'b0;
            out_err              <= 1'b0;
            out_remote_blocklock <= '0;
            out_aligned          <= 1'b0;
            out_err_cnt          <= '0;
        end else begin
            state_q              <= state_d;
            out_rxdata_en        <= rxdata_en_d;
            out_rxdata           <= rxdata_d;
            out_idle             <= idle_d;
            out_sync             <= sync_d;
            out_err              <= err_d;
            out_remote_blocklock <= blocklock_d;
            out_aligned          <= aligned_d;
            out_err_cnt          <= err_cnt_d;
        end
    end

endmodule

// File: tb/tb_rx_descaper.sv
// Directed self-checking bench for rx_descaper with hand-computed expectations.
module tb_rx_descaper;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_enable;
    logic [2:0]  in_lane_id;
    logic        in_rxdata_en;
    logic [15:0] in_rxdata;
    logic        out_rxdata_en;
    logic [15:0] out_rxdata;
    logic        out_idle;
    logic        out_sync;
    logic [3:0]  out_remote_blocklock;
    logic        out_aligned;
    logic        out_err;
    logic [15:0] out_err_cnt;

    int unsigned total  = 0;
    int unsigned passed = 0;

    localparam logic [15:0] ESC  = 16'h7E5A;
    localparam logic [15:0] IDLE = 16'h7E00;

    rx_descaper dut (
        .clk                  (clk),
        .reset                (reset),
        .in_enable            (in_enable),
        .in_lane_id           (in_lane_id),
        .in_rxdata_en         (in_rxdata_en),
        .in_rxdata            (in_rxdata),
        .out_rxdata_en        (out_rxdata_en),
        .out_rxdata           (out_rxdata),
        .out_idle             (out_idle),
        .out_sync             (out_sync),
        .out_remote_blocklock (out_remote_blocklock),
        .out_aligned          (out_aligned),
        .out_err              (out_err),
        .out_err_cnt          (out_err_cnt)
    );

    always #5 clk = ~clk;

    task automatic cyc(input logic en, input logic vld, input logic [15:0] d);
        in_enable    = en;
        in_rxdata_en = vld;
        in_rxdata    = d;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Pulse vector packed as {rxdata_en, idle, sync, err}.
    task automatic chk_out(input string tag, input logic [3:0] pulses, input logic [15:0] data);
        chk({tag, "_pulses"}, {28'd0, out_rxdata_en, out_idle, out_sync, out_err}, {28'd0, pulses});
        chk({tag, "_data"}, {16'd0, out_rxdata}, {16'd0, data});
    endtask

    initial begin
        reset = 1'b1; in_enable = 1'b0; in_lane_id = 3'd2;
        in_rxdata_en = 1'b0; in_rxdata = '0;
        cyc(1'b1, 1'b0, 16'h0);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("reset", 4'b0000, 16'h0000);
        chk("reset_aligned", {31'd0, out_aligned}, 32'd0);
        chk("reset_cnt", {16'd0, out_err_cnt}, 32'd0);
        chk("reset_bl", {28'd0, out_remote_blocklock}, 32'd0);
        reset = 1'b0;

        // 1: plain data, one cycle latency
        cyc(1'b1, 1'b1, 16'h1234);
        chk_out("t1_a", 4'b1000, 16'h1234);
        cyc(1'b1, 1'b1, 16'h5678);
        chk_out("t1_b", 4'b1000, 16'h5678);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t1_gap", 4'b0000, 16'h5678);

        // 2: escaped ESC, then idle pair
        cyc(1'b1, 1'b1, ESC);
        chk_out("t2_esc1", 4'b0000, 16'h5678);
        cyc(1'b1, 1'b1, ESC);
        chk_out("t2_escdata", 4'b1000, ESC);
        cyc(1'b1, 1'b1, ESC);
        chk_out("t2_esc2", 4'b0000, ESC);
        cyc(1'b1, 1'b1, IDLE);
        chk_out("t2_idle", 4'b0100, ESC);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t2_after", 4'b0000, ESC);

        // 3: valid sync on lane 2, blocklock B
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'hEA0B);
        chk_out("t3_sync", 4'b0010, ESC);
        chk("t3_bl", {28'd0, out_remote_blocklock}, 32'hB);
        chk("t3_aligned", {31'd0, out_aligned}, 32'd1);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t3_after", 4'b0000, ESC);
        chk("t3_aligned_hold", {31'd0, out_aligned}, 32'd1);

        // 4: wrong lane id, then unknown control unit
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'hEB0B);
        chk_out("t4_lane", 4'b0001, ESC);
        chk("t4_cnt1", {16'd0, out_err_cnt}, 32'd1);
        chk("t4_aligned0", {31'd0, out_aligned}, 32'd0);
        chk("t4_bl_hold", {28'd0, out_remote_blocklock}, 32'hB);
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'h1111);
        chk_out("t4_other", 4'b0001, ESC);
        chk("t4_cnt2", {16'd0, out_err_cnt}, 32'd2);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t4_gap", 4'b0000, ESC);
        // realign, then sync with nonzero reserved bits
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'hEA05);
        chk_out("t4_resync", 4'b0010, ESC);
        chk("t4_bl5", {28'd0, out_remote_blocklock}, 32'h5);
        chk("t4_aligned1", {31'd0, out_aligned}, 32'd1);
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'hEA15);
        chk_out("t4_rsvd", 4'b0001, ESC);
        chk("t4_cnt3", {16'd0, out_err_cnt}, 32'd3);
        chk("t4_aligned_rsvd", {31'd0, out_aligned}, 32'd0);
        chk("t4_bl5_hold", {28'd0, out_remote_blocklock}, 32'h5);

        // 5: gaps and disabled cycles inside an ESC pair
        cyc(1'b1, 1'b1, ESC);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 1'b0, IDLE);
            chk_out("t5_gap", 4'b0000, ESC);
        end
        cyc(1'b0, 1'b1, IDLE);
        chk_out("t5_dis1", 4'b0000, ESC);
        cyc(1'b0, 1'b1, 16'h4321);
        chk_out("t5_dis2", 4'b0000, ESC);
        cyc(1'b1, 1'b1, IDLE);
        chk_out("t5_idle", 4'b0100, ESC);
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t5_after", 4'b0000, ESC);

        // 6: reset mid-pair discards ESC
        cyc(1'b1, 1'b1, ESC);
        reset = 1'b1;
        cyc(1'b1, 1'b0, 16'h0);
        chk_out("t6_rst", 4'b0000, 16'h0000);
        chk("t6_rst_cnt", {16'd0, out_err_cnt}, 32'd0);
        chk("t6_rst_bl", {28'd0, out_remote_blocklock}, 32'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b1, IDLE);
        chk_out("t6_idle_data", 4'b1000, IDLE);

        // 6: saturation from a preloaded count
        force dut.out_err_cnt = 16'hFFFE;
        #1;
        release dut.out_err_cnt;
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'h2222);
        chk_out("t6_err1", 4'b0001, IDLE);
        chk("t6_cnt_ffff", {16'd0, out_err_cnt}, 32'hFFFF);
        cyc(1'b1, 1'b1, ESC);
        cyc(1'b1, 1'b1, 16'h3333);
        chk_out("t6_err2", 4'b0001, IDLE);
        chk("t6_cnt_sat", {16'd0, out_err_cnt}, 32'hFFFF);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
